// File: rtl/z2_bus_master.sv
// z2_bus_master: 68000 / Zorro II bus initiator.
// Requests the bus with BR/BG/BGACK, then runs one word read or write per request
// for an internal requester. All bus pins are registered. Tristate buffers live in
// the top level and are steered by BUS_OE and DATA_OE.
// Optional build macro BUS_TIMEOUT_EN: when defined, a cycle left in WAIT for
// TIMEOUT_CLKS clocks without DTACK or BERR ends with an err pulse.
module z2_bus_master #(
  parameter int unsigned SETUP_CLKS   = 2,
  parameter int unsigned RELEASE_CLKS = 1,
  parameter int unsigned TIMEOUT_CLKS = 255
) (
  input  logic        MEMCLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_write,
  input  logic [22:0] req_addr,
  input  logic        req_uds,
  input  logic        req_lds,
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [22:0] ADDR_OUT,
  output logic [15:0] DOUT,
  input  logic [15:0] DIN,
  output logic        DATA_OE,
  output logic        BUS_OE,
  output logic        AS_n_OUT,
  output logic        UDS_n_OUT,
  output logic        LDS_n_OUT,
  output logic        RW_OUT,
  input  logic        AS_n_IN,
  input  logic        DTACK_n,
  input  logic        BERR_n,
  output logic        BR_n,
  input  logic        BG_n,
  output logic        BGACK_n
);

  // SETUP_CLKS below 1 behaves as 1.
  localparam logic [7:0] SetupLast  = (SETUP_CLKS > 1) ? 8'(SETUP_CLKS - 1) : 8'd0;
  localparam logic [7:0] ReleaseCnt = 8'(RELEASE_CLKS);

  typedef enum logic [2:0] {
    StIdle, StArb, StAddr, StStrobe, StWait, StLatch, StNegate
  } state_e;

  // Synchroniser bit order: {AS_n_IN, BG_n, BERR_n, DTACK_n}.
  logic [3:0] sync1_q, sync2_q;
  logic       dtack_s, berr_s, bg_s, as_s;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d, uds_q, uds_d, lds_q, lds_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic [15:0] rdata_q, rdata_d;
  logic [22:0] addr_out_q, addr_out_d;
  logic [15:0] dout_q, dout_d;
  logic        data_oe_q, data_oe_d, bus_oe_q, bus_oe_d;
  logic        as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d, rw_q, rw_d;
  logic        br_n_q, br_n_d, bgack_n_q, bgack_n_d;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned     TmoW    = ($clog2(TIMEOUT_CLKS + 1) > 8) ?
                                        $clog2(TIMEOUT_CLKS + 1) : 8;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CLKS - 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`else
  // TIMEOUT_CLKS has no effect in this build; WAIT ends only on DTACK or BERR.
  if (TIMEOUT_CLKS == 0) begin : g_no_timeout
  end
`endif

  // Two-flop synchronisers for the asynchronous bus inputs, idle value 1.
  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {AS_n_IN, BG_n, BERR_n, DTACK_n};
      sync2_q <= sync1_q;
    end
  end

  assign dtack_s = sync2_q[0];
  assign berr_s  = sync2_q[1];
  assign bg_s    = sync2_q[2];
  assign as_s    = sync2_q[3];

  // Next-state and registered-output logic for the bus cycle sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    uds_d      = uds_q;
    lds_d      = lds_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    addr_out_d = addr_out_q;
    dout_d     = dout_q;
    data_oe_d  = data_oe_q;
    bus_oe_d   = bus_oe_q;
    as_n_d     = as_n_q;
    uds_n_d    = uds_n_q;
    lds_n_d    = lds_n_q;
    rw_d       = rw_q;
    br_n_d     = br_n_q;
    bgack_n_d  = bgack_n_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        // ack_q guard keeps a requester that drops req late from getting a second pulse.
        if (req && !ack_q) begin
          if (!req_uds && !req_lds) begin
            ack_d = 1'b1;
          end else begin
            wr_d    = req_write;
            addr_d  = req_addr;
            uds_d   = req_uds;
            lds_d   = req_lds;
            wdata_d = req_wdata;
            br_n_d  = 1'b0;
            state_d = StArb;
          end
        end
      end
      StArb: begin
        // Previous master must have finished: granted, AS and DTACK both idle.
        if (!bg_s && as_s && dtack_s) begin
          bgack_n_d  = 1'b0;
          br_n_d     = 1'b1;
          bus_oe_d   = 1'b1;
          addr_out_d = addr_q;
          rw_d       = ~wr_q;
          data_oe_d  = wr_q;
          if (wr_q) dout_d = wdata_q;
          cnt_d      = '0;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (cnt_q >= SetupLast) begin
          as_n_d = 1'b0;
          if (!wr_q) begin
            uds_n_d = ~uds_q;
            lds_n_d = ~lds_q;
          end
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StStrobe: begin
        // Writes get their data strobes one clock after AS.
        uds_n_d = ~uds_q;
        lds_n_d = ~lds_q;
        state_d = StWait;
`ifdef BUS_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      StWait: begin
        if (!berr_s) begin
          err_d     = 1'b1;
          as_n_d    = 1'b1;
          uds_n_d   = 1'b1;
          lds_n_d   = 1'b1;
          data_oe_d = 1'b0;
          cnt_d     = '0;
          state_d   = StNegate;
        end else if (!dtack_s) begin
          state_d = StLatch;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          err_d     = 1'b1;
          as_n_d    = 1'b1;
          uds_n_d   = 1'b1;
          lds_n_d   = 1'b1;
          data_oe_d = 1'b0;
          cnt_d     = '0;
          state_d   = StNegate;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      StLatch: begin
        // One clock after DTACK was seen, giving the slave's data time to settle.
        if (!wr_q) rdata_d = DIN;
        ack_d     = 1'b1;
        as_n_d    = 1'b1;
        uds_n_d   = 1'b1;
        lds_n_d   = 1'b1;
        data_oe_d = 1'b0;
        cnt_d     = '0;
        state_d   = StNegate;
      end
      StNegate: begin
        if (!dtack_s || !berr_s) begin
          cnt_d = '0;
        end else if (cnt_q >= ReleaseCnt) begin
          if (req && (req_uds || req_lds)) begin
            // Bus hold: next request runs without releasing BGACK.
            wr_d       = req_write;
            addr_d     = req_addr;
            uds_d      = req_uds;
            lds_d      = req_lds;
            wdata_d    = req_wdata;
            addr_out_d = req_addr;
            rw_d       = ~req_write;
            data_oe_d  = req_write;
            if (req_write) dout_d = req_wdata;
            cnt_d      = '0;
            state_d    = StAddr;
          end else begin
            bgack_n_d = 1'b1;
            bus_oe_d  = 1'b0;
            rw_d      = 1'b1;
            state_d   = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; RESET drops the bus at once, even mid-cycle.
  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      uds_q      <= 1'b0;
      lds_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      addr_out_q <= '0;
      dout_q     <= '0;
      data_oe_q  <= 1'b0;
      bus_oe_q   <= 1'b0;
      as_n_q     <= 1'b1;
      uds_n_q    <= 1'b1;
      lds_n_q    <= 1'b1;
      rw_q       <= 1'b1;
      br_n_q     <= 1'b1;
      bgack_n_q  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      uds_q      <= uds_d;
      lds_q      <= lds_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      addr_out_q <= addr_out_d;
      dout_q     <= dout_d;
      data_oe_q  <= data_oe_d;
      bus_oe_q   <= bus_oe_d;
      as_n_q     <= as_n_d;
      uds_n_q    <= uds_n_d;
      lds_n_q    <= lds_n_d;
      rw_q       <= rw_d;
      br_n_q     <= br_n_d;
      bgack_n_q  <= bgack_n_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign rdata     = rdata_q;
  assign ADDR_OUT  = addr_out_q;
  assign DOUT      = dout_q;
  assign DATA_OE   = data_oe_q;
  assign BUS_OE    = bus_oe_q;
  assign AS_n_OUT  = as_n_q;
  assign UDS_n_OUT = uds_n_q;
  assign LDS_n_OUT = lds_n_q;
  assign RW_OUT    = rw_q;
  assign BR_n      = br_n_q;
  assign BGACK_n   = bgack_n_q;

endmodule

// File: tb/tb_z2_bus_master.sv
// Bench for z2_bus_master: behavioural arbiter and bus slave, word-memory reference model.
module tb_z2_bus_master;

  localparam int unsigned SetupClks = 2;
  localparam int unsigned TmoClks   = 16;

  logic        MEMCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req = 1'b0, req_write = 1'b0, req_uds = 1'b0, req_lds = 1'b0;
  logic [22:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        ack, err, busy;
  logic [15:0] rdata, DOUT;
  logic [15:0] DIN = '0;
  logic [22:0] ADDR_OUT;
  logic        DATA_OE, BUS_OE, AS_n_OUT, UDS_n_OUT, LDS_n_OUT, RW_OUT;
  logic        AS_n_IN;
  logic        DTACK_n = 1'b1, BERR_n = 1'b1, BG_n = 1'b1;
  logic        BR_n, BGACK_n;

  // Our own AS is the only one on this bus.
  assign AS_n_IN = BUS_OE ? AS_n_OUT : 1'b1;

  z2_bus_master #(
    .SETUP_CLKS  (SetupClks),
    .RELEASE_CLKS(1),
    .TIMEOUT_CLKS(TmoClks)
  ) dut (
    .MEMCLK   (MEMCLK),
    .RESET    (RESET),
    .req      (req),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_uds  (req_uds),
    .req_lds  (req_lds),
    .req_wdata(req_wdata),
    .ack      (ack),
    .err      (err),
    .rdata    (rdata),
    .busy     (busy),
    .ADDR_OUT (ADDR_OUT),
    .DOUT     (DOUT),
    .DIN      (DIN),
    .DATA_OE  (DATA_OE),
    .BUS_OE   (BUS_OE),
    .AS_n_OUT (AS_n_OUT),
    .UDS_n_OUT(UDS_n_OUT),
    .LDS_n_OUT(LDS_n_OUT),
    .RW_OUT   (RW_OUT),
    .AS_n_IN  (AS_n_IN),
    .DTACK_n  (DTACK_n),
    .BERR_n   (BERR_n),
    .BR_n     (BR_n),
    .BG_n     (BG_n),
    .BGACK_n  (BGACK_n)
  );

  always #5 MEMCLK = ~MEMCLK;

  int checks = 0;
  int errors = 0;

  // Environment knobs: resp_mode 0 = DTACK, 1 = BERR with DTACK, 2 = silent.
  int grant_delay = 0, dtack_delay = 0, resp_mode = 0;

  // Monitor observations.
  int cyc = 0, ack_cnt = 0, err_cnt = 0, err_cyc = 0, as_fall_cnt = 0, as_fall_cyc = 0;
  int lds_fall_cyc = 0, uds_fall_cyc = 0, uds_fall_cnt = 0, br_fall_cnt = 0;
  int bgack_rise_cnt = 0, boe_rise_cyc = 0;
  bit both_seen = 0, doe_at_as = 0, doe_at_lds = 0, doe_at_boe = 0;
  logic [15:0] dout_at_as = '0;

  // Slave observations.
  logic [22:0] obs_addr = '0;
  logic        obs_rw = 1'b0, obs_u = 1'b0, obs_l = 1'b0;

  logic [15:0] slave_mem [logic [22:0]];
  logic [15:0] model_mem [logic [22:0]];

  function automatic logic [15:0] init_word(input logic [22:0] a);
    return {a[7:0], a[22:15]} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] slave_get(input logic [22:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] model_read(input logic [22:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic void model_write(input logic [22:0] a, input logic u, input logic l,
                                      input logic [15:0] d);
    logic [15:0] w;
    w = model_read(a);
    if (u) w[15:8] = d[15:8];
    if (l) w[7:0] = d[7:0];
    model_mem[a] = w;
  endfunction

  // Arbiter: grant grant_delay clocks after BR, withdraw once BGACK is seen.
  initial begin
    int gcnt;
    gcnt = 0;
    forever begin
      @(negedge MEMCLK);
      if (RESET || !BGACK_n || BR_n) begin
        BG_n = 1'b1;
        gcnt = 0;
      end else if (BG_n) begin
        if (gcnt >= grant_delay) BG_n = 1'b0;
        else gcnt++;
      end
    end
  end

  // Bus slave: answers dtack_delay clocks after a data strobe, releases on AS negation.
  initial begin
    int rcnt;
    bit responded;
    logic [15:0] w;
    rcnt = 0;
    responded = 0;
    forever begin
      @(negedge MEMCLK);
      if (AS_n_OUT || RESET) begin
        DTACK_n = 1'b1;
        BERR_n = 1'b1;
        rcnt = 0;
        responded = 0;
      end else if (!responded && (!UDS_n_OUT || !LDS_n_OUT)) begin
        if (rcnt >= dtack_delay) begin
          responded = 1;
          obs_addr = ADDR_OUT;
          obs_rw = RW_OUT;
          obs_u = ~UDS_n_OUT;
          obs_l = ~LDS_n_OUT;
          if (resp_mode == 1) begin
            DTACK_n = 1'b0;
            BERR_n = 1'b0;
          end else if (resp_mode == 0) begin
            if (RW_OUT) begin
              DIN = slave_get(ADDR_OUT);
            end else begin
              w = slave_get(ADDR_OUT);
              if (!UDS_n_OUT) w[15:8] = DOUT[15:8];
              if (!LDS_n_OUT) w[7:0] = DOUT[7:0];
              slave_mem[ADDR_OUT] = w;
            end
            DTACK_n = 1'b0;
          end
        end else begin
          rcnt++;
        end
      end
    end
  end

  // Edge and pulse monitor.
  initial begin
    logic p_as, p_lds, p_uds, p_br, p_bgack, p_boe;
    {p_as, p_lds, p_uds, p_br, p_bgack, p_boe} = 6'b111110;
    forever begin
      @(negedge MEMCLK);
      cyc++;
      if (ack) ack_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (ack && err) both_seen = 1;
      if (p_as && !AS_n_OUT) begin
        as_fall_cnt++;
        as_fall_cyc = cyc;
        dout_at_as = DOUT;
        doe_at_as = DATA_OE;
      end
      if (p_lds && !LDS_n_OUT) begin
        lds_fall_cyc = cyc;
        doe_at_lds = DATA_OE;
      end
      if (p_uds && !UDS_n_OUT) begin
        uds_fall_cnt++;
        uds_fall_cyc = cyc;
      end
      if (p_br && !BR_n) br_fall_cnt++;
      if (!p_bgack && BGACK_n) bgack_rise_cnt++;
      if (!p_boe && BUS_OE) begin
        boe_rise_cyc = cyc;
        doe_at_boe = DATA_OE;
      end
      {p_as, p_lds, p_uds, p_br, p_bgack, p_boe} =
          {AS_n_OUT, LDS_n_OUT, UDS_n_OUT, BR_n, BGACK_n, BUS_OE};
    end
  end

  task automatic clear_counts();
    ack_cnt = 0;
    err_cnt = 0;
    as_fall_cnt = 0;
    uds_fall_cnt = 0;
    br_fall_cnt = 0;
    bgack_rise_cnt = 0;
  endtask

  // Issue one request and wait (bounded) for its completion pulse.
  task automatic run_xfer(input logic wr, input logic [22:0] a, input logic u, input logic l,
                          input logic [15:0] wd, input bit keep_req, output bit got_ack,
                          output bit got_err, output bit timed_out, output logic [15:0] rd);
    req = 1'b1;
    req_write = wr;
    req_addr = a;
    req_uds = u;
    req_lds = l;
    req_wdata = wd;
    got_ack = 0;
    got_err = 0;
    timed_out = 1;
    rd = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge MEMCLK);
      if (ack || err) begin
        got_ack = ack;
        got_err = err;
        rd = rdata;
        timed_out = 0;
        if (!keep_req) req = 1'b0;
        break;
      end
    end
    if (timed_out) req = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge MEMCLK);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge MEMCLK);
    checks++;
    if ({AS_n_OUT, UDS_n_OUT, LDS_n_OUT, BR_n, BGACK_n, RW_OUT} !== 6'b111111) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 111111",
               {AS_n_OUT, UDS_n_OUT, LDS_n_OUT, BR_n, BGACK_n, RW_OUT});
    end
    checks++;
    if ({BUS_OE, DATA_OE, ack, err, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {BUS_OE, DATA_OE, ack, err, busy});
    end
    checks++;
    if ({rdata, ADDR_OUT, DOUT} !== 55'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", rdata, ADDR_OUT, DOUT);
    end
    RESET = 1'b0;
    repeat (3) @(negedge MEMCLK);
  endtask

  task automatic test_read();
    bit ga, ge, to, ok;
    logic [15:0] rd;
    slave_mem[23'h7FFFFF] = 16'hA55A;
    model_mem[23'h7FFFFF] = 16'hA55A;
    grant_delay = 3;
    dtack_delay = 5;
    resp_mode = 0;
    clear_counts();
    run_xfer(1'b0, 23'h7FFFFF, 1'b1, 1'b1, 16'h0000, 0, ga, ge, to, rd);
    wait_idle(ok);
    checks++;
    if (!(ga && !ge && !to && ok)) begin
      errors++;
      $display("FAIL read_done: got ack=%0b err=%0b to=%0b idle=%0b expected 1 0 0 1",
               ga, ge, to, ok);
    end
    checks++;
    if (rd !== model_read(23'h7FFFFF)) begin
      errors++;
      $display("FAIL read_data: got %h expected %h", rd, model_read(23'h7FFFFF));
    end
    checks++;
    if ({obs_addr, obs_rw, obs_u, obs_l} !== {23'h7FFFFF, 3'b111}) begin
      errors++;
      $display("FAIL read_bus: got addr=%h rw/u/l=%b expected 7fffff 111", obs_addr,
               {obs_rw, obs_u, obs_l});
    end
    checks++;
    if (uds_fall_cyc != as_fall_cyc || lds_fall_cyc != as_fall_cyc) begin
      errors++;
      $display("FAIL read_strobe_align: got as=%0d uds=%0d lds=%0d expected equal",
               as_fall_cyc, uds_fall_cyc, lds_fall_cyc);
    end
    checks++;
    if (as_fall_cyc - boe_rise_cyc != int'(SetupClks)) begin
      errors++;
      $display("FAIL read_setup: got %0d expected %0d", as_fall_cyc - boe_rise_cyc, SetupClks);
    end
    checks++;
    if (ack_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL read_pulses: got ack=%0d err=%0d expected 1 0", ack_cnt, err_cnt);
    end
    checks++;
    if ({AS_n_OUT, BGACK_n, BUS_OE, rdata} !== {3'b110, 16'hA55A}) begin
      errors++;
      $display("FAIL read_release: got %b rdata=%h expected 110 a55a",
               {AS_n_OUT, BGACK_n, BUS_OE}, rdata);
    end
  endtask

  task automatic test_write();
    bit ga, ge, to, ok;
    logic [15:0] rd;
    grant_delay = 1;
    dtack_delay = 2;
    resp_mode = 0;
    clear_counts();
    model_write(23'h200000, 1'b0, 1'b1, 16'h1234);
    run_xfer(1'b1, 23'h200000, 1'b0, 1'b1, 16'h1234, 0, ga, ge, to, rd);
    wait_idle(ok);
    checks++;
    if (!(ga && !ge && !to && ok)) begin
      errors++;
      $display("FAIL write_done: got ack=%0b err=%0b to=%0b idle=%0b expected 1 0 0 1",
               ga, ge, to, ok);
    end
    checks++;
    if (uds_fall_cnt != 0 || {obs_rw, obs_u, obs_l} !== 3'b001) begin
      errors++;
      $display("FAIL write_strobes: got uds_falls=%0d rw/u/l=%b expected 0 001", uds_fall_cnt,
               {obs_rw, obs_u, obs_l});
    end
    checks++;
    if (lds_fall_cyc != as_fall_cyc + 1) begin
      errors++;
      $display("FAIL write_lds_delay: got %0d expected %0d", lds_fall_cyc, as_fall_cyc + 1);
    end
    checks++;
    if (!(doe_at_boe && doe_at_as && doe_at_lds) || dout_at_as !== 16'h1234) begin
      errors++;
      $display("FAIL write_drive: got oe=%b dout=%h expected 111 1234",
               {doe_at_boe, doe_at_as, doe_at_lds}, dout_at_as);
    end
    checks++;
    if (slave_get(23'h200000) !== model_read(23'h200000)) begin
      errors++;
      $display("FAIL write_mem: got %h expected %h", slave_get(23'h200000),
               model_read(23'h200000));
    end
  endtask

  task automatic test_berr();
    bit ga, ge, to, ok;
    logic [15:0] rd;
    grant_delay = 0;
    dtack_delay = 1;
    resp_mode = 1;
    clear_counts();
    run_xfer(1'b0, 23'h012345, 1'b1, 1'b0, 16'h0000, 0, ga, ge, to, rd);
    wait_idle(ok);
    checks++;
    if (!(!ga && ge && !to)) begin
      errors++;
      $display("FAIL berr_result: got ack=%0b err=%0b to=%0b expected 0 1 0", ga, ge, to);
    end
    checks++;
    if (ack_cnt != 0 || err_cnt != 1) begin
      errors++;
      $display("FAIL berr_pulses: got ack=%0d err=%0d expected 0 1", ack_cnt, err_cnt);
    end
    checks++;
    if (!ok || {BGACK_n, BUS_OE} !== 2'b10) begin
      errors++;
      $display("FAIL berr_idle: got idle=%0b bgack/oe=%b expected 1 10", ok, {BGACK_n, BUS_OE});
    end
    resp_mode = 0;
  endtask

  task automatic test_back_to_back();
    bit ga1, ge1, to1, ga2, ge2, to2, ok;
    logic [15:0] rd1, rd2;
    grant_delay = 2;
    dtack_delay = 1;
    resp_mode = 0;
    clear_counts();
    run_xfer(1'b0, 23'h000111, 1'b1, 1'b1, 16'h0000, 1, ga1, ge1, to1, rd1);
    run_xfer(1'b0, 23'h000222, 1'b1, 1'b1, 16'h0000, 0, ga2, ge2, to2, rd2);
    checks++;
    if (!(ga1 && ga2 && !to1 && !to2) || rd1 !== model_read(23'h000111) ||
        rd2 !== model_read(23'h000222)) begin
      errors++;
      $display("FAIL b2b_data: got %h %h (ack %0b%0b) expected %h %h", rd1, rd2, ga1, ga2,
               model_read(23'h000111), model_read(23'h000222));
    end
    checks++;
    if (br_fall_cnt != 1 || bgack_rise_cnt != 0) begin
      errors++;
      $display("FAIL b2b_hold: got br_falls=%0d bgack_rises=%0d expected 1 0", br_fall_cnt,
               bgack_rise_cnt);
    end
    wait_idle(ok);
    checks++;
    if (!ok || bgack_rise_cnt != 1) begin
      errors++;
      $display("FAIL b2b_release: got idle=%0b bgack_rises=%0d expected 1 1", ok, bgack_rise_cnt);
    end
  endtask

  task automatic test_random();
    bit ga, ge, to, ok, wr, u, l;
    logic [22:0] a;
    logic [15:0] wd, rd, exp_rd;
    int mode;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1 ? 23'h7FFFF8 : 23'h000000) | 23'($urandom_range(0, 7));
      u = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
      grant_delay = $urandom_range(0, 4);
      dtack_delay = $urandom_range(0, 4);
      resp_mode = mode;
      clear_counts();
      exp_rd = model_read(a);
      run_xfer(wr, a, u, l, wd, 0, ga, ge, to, rd);
      wait_idle(ok);
      if (!u && !l) begin
        checks++;
        if (!(ga && !ge && ok) || as_fall_cnt != 0 || br_fall_cnt != 0) begin
          errors++;
          $display("FAIL rnd_noenable[%0d]: got ack=%0b err=%0b as=%0d br=%0d expected 1 0 0 0",
                   n, ga, ge, as_fall_cnt, br_fall_cnt);
        end
      end else begin
        checks++;
        if (ga !== (mode == 0) || ge !== (mode == 1) || to || !ok ||
            ack_cnt + err_cnt != 1) begin
          errors++;
          $display("FAIL rnd_outcome[%0d]: got ack=%0b err=%0b pulses=%0d expected mode %0d",
                   n, ga, ge, ack_cnt + err_cnt, mode);
        end
        checks++;
        if ({obs_addr, obs_rw, obs_u, obs_l} !== {a, ~wr, u, l}) begin
          errors++;
          $display("FAIL rnd_bus[%0d]: got %h %b expected %h %b", n, obs_addr,
                   {obs_rw, obs_u, obs_l}, a, {~wr, u, l});
        end
        if (mode == 0 && wr) model_write(a, u, l, wd);
        if (mode == 0 && !wr) begin
          checks++;
          if (rd !== exp_rd) begin
            errors++;
            $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, rd, exp_rd);
          end
        end
        if (mode == 0 && wr) begin
          checks++;
          if (slave_get(a) !== model_read(a)) begin
            errors++;
            $display("FAIL rnd_wmem[%0d]: got %h expected %h", n, slave_get(a), model_read(a));
          end
        end
      end
    end
    resp_mode = 0;
    checks++;
    if (both_seen) begin
      errors++;
      $display("FAIL ack_err_overlap: got 1 expected 0");
    end
  endtask

  task automatic test_reset_mid();
    bit in_wait;
    grant_delay = 0;
    dtack_delay = 0;
    resp_mode = 2;
    req_write = 1'b0;
    req_addr = 23'h0ABCDE;
    req_uds = 1'b1;
    req_lds = 1'b1;
    req = 1'b1;
    in_wait = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge MEMCLK);
      if (!AS_n_OUT && !LDS_n_OUT) begin
        in_wait = 1;
        break;
      end
    end
    repeat (3) @(negedge MEMCLK);
    RESET = 1'b1;
    @(negedge MEMCLK);
    checks++;
    if (!in_wait || {AS_n_OUT, BGACK_n, BUS_OE, busy, ack, err} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_mid: got reached=%0b as/bgack/oe/busy/ack/err=%b expected 1 110000",
               in_wait, {AS_n_OUT, BGACK_n, BUS_OE, busy, ack, err});
    end
    req = 1'b0;
    RESET = 1'b0;
    resp_mode = 0;
    repeat (4) @(negedge MEMCLK);
  endtask

  task automatic test_timeout();
    resp_mode = 2;
    grant_delay = 0;
    dtack_delay = 0;
    clear_counts();
`ifdef BUS_TIMEOUT_EN
    begin
      bit ga, ge, to, ok;
      logic [15:0] rd;
      run_xfer(1'b1, 23'h000300, 1'b0, 1'b1, 16'hBEEF, 0, ga, ge, to, rd);
      wait_idle(ok);
      checks++;
      if (!(ge && !ga && !to && ok)) begin
        errors++;
        $display("FAIL timeout_err: got ack=%0b err=%0b to=%0b expected 0 1 0", ga, ge, to);
      end
      checks++;
      if (err_cyc - lds_fall_cyc != int'(TmoClks)) begin
        errors++;
        $display("FAIL timeout_delay: got %0d expected %0d", err_cyc - lds_fall_cyc, TmoClks);
      end
    end
`else
    req_write = 1'b0;
    req_addr = 23'h000300;
    req_uds = 1'b1;
    req_lds = 1'b1;
    req = 1'b1;
    repeat (1000) @(negedge MEMCLK);
    checks++;
    if (err_cnt != 0 || ack_cnt != 0 || !busy || AS_n_OUT) begin
      errors++;
      $display("FAIL no_timeout: got err=%0d ack=%0d busy=%0b as_n=%0b expected 0 0 1 0",
               err_cnt, ack_cnt, busy, AS_n_OUT);
    end
    RESET = 1'b1;
    req = 1'b0;
    @(negedge MEMCLK);
    RESET = 1'b0;
    repeat (3) @(negedge MEMCLK);
`endif
    resp_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_berr();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
